mux_pipe_param: RTL and testbench
=================================

MUX_PIPE_PARAM -- requirements
Module: mux_pipe_param

Interface
REQ-001 Parameter WIDTH, default 4, bit width of each input channel and of out_data.
REQ-002 Parameter SEL_W, default 6, select width; NUM_IN = 2^SEL_W channels; SEL_W SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_bus  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 sel  input  SEL_W  channel index used in direct mode.
REQ-007 mode  input  1  selection mode: 0 = direct (uses sel), 1 = scan (uses the internal counter).
REQ-008 scan_clr  input  1  synchronous clear of the scan counter.
REQ-009 in_valid  input  1  the request on in_bus, sel and mode is valid.
REQ-010 in_ready  output  1  the block accepts a request this cycle.
REQ-011 out_data  output  WIDTH  selected channel value.
REQ-012 out_sel  output  SEL_W  channel index that produced out_data.
REQ-013 out_last  output  1  set when out_sel = NUM_IN-1 and the request was a scan-mode request.
REQ-014 out_valid  output  1  out_data, out_sel and out_last are valid.
REQ-015 out_ready  input  1  the downstream side accepts the output.

Function
REQ-016 Accept: a request is accepted when in_valid && in_ready; transfer: an output is transferred when out_valid && out_ready.
REQ-017 Effective index idx is sel when mode=0. When mode=1, idx is the scan counter value; it is 0 if scan_clr is asserted in the same cycle.
REQ-018 Stage 1 (S1), on accept, SHALL register:
- lo = channel idx[SEL_W-2:0] of the lower half (channels 0..NUM_IN/2-1);
- hi = the same offset in the upper half;
- idx, mode, and s1_valid=1.
REQ-019 Stage 2 (S2), on load, SHALL register out_data = idx[SEL_W-1] ? hi : lo, together with out_sel = idx, out_last, and out_valid=1.
REQ-020 Latency SHALL be 2 cycles from accept to out_valid when there is no backpressure; throughput SHALL be one request per cycle.
REQ-021 s2_load = s1_valid && (!out_valid || out_ready).
REQ-022 s1_en = !s1_valid || s2_load.
REQ-023 in_ready = s1_en, a combinational function of registered state and out_ready only.
REQ-024 With out_ready=0 and both stages full, S1 and S2 SHALL hold their values unchanged and in_ready SHALL be 0; no request SHALL be lost or duplicated.
REQ-025 When s1_en=1 and there is no accept, s1_valid SHALL clear; when an output transfers with no s2_load, out_valid SHALL clear.
REQ-026 Scan counter (SEL_W bits) update priority:
- scan_clr: counter = 1 if a scan-mode accept occurs this cycle, else 0;
- otherwise, a scan-mode accept increments the counter;
- otherwise, the counter holds.
REQ-027 The scan counter SHALL wrap from NUM_IN-1 to 0 without stall or flag other than out_last.
REQ-028 Direct-mode accepts SHALL NOT modify the scan counter; mode may change on any accept.
REQ-029 in_bus and sel SHALL be sampled only on accept; changes at other times SHALL have no effect.

Reset
REQ-030 While rst_n=0, regardless of clk:
- s1_valid, out_valid, out_last, out_data, out_sel and the scan counter SHALL be 0;
- in_ready SHALL therefore be 1 on the first clk edge after release.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight requests; no output transfer SHALL occur for them after release.

Verification
REQ-032 WIDTH=4, SEL_W=6, channel k = k mod 16, out_ready=1:
- stimulus: direct sel=0, 31, 32, 63 on consecutive cycles;
- response: out_data 0, 15, 0, 15 and out_sel 0, 31, 32, 63 on cycles 2..5, out_last=0.
REQ-033 Scan mode, in_valid=1 for 65 cycles, out_ready=1 -> out_sel 0..63 then 0; out_last=1 only on out_sel=63.
REQ-034 Backpressure:
- stimulus: 3 back-to-back accepts (sel=5, 6, 7), then out_ready=0 for 4 cycles;
- response: in_ready=0 while both stages are full; after release, outputs 5, 6, 7 appear in order, none dropped or duplicated.
REQ-035 scan_clr with an accept while the counter=40 -> that output has out_sel=0, the next scan output has out_sel=1; a direct accept between them does not advance the counter.
REQ-036 rst_n pulsed low with both stages valid -> out_valid=0 immediately; no output appears after release until a new accept; the next scan index is 0.
REQ-037 WIDTH=8, SEL_W=2, random in_bus/sel/in_valid/out_ready for 10k cycles -> scoreboard match with REQ-017..REQ-029.

Source files
------------

// File: rtl/mux_pipe_param.sv
// mux_pipe_param: two-stage pipelined 2^SEL_W:1 mux with direct/scan selection and valid/ready flow control
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_bus            : NUM_IN channels of WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   sel, mode         : direct channel index / 0 = direct, 1 = scan counter
//   scan_clr          : synchronous clear of the scan counter
//   in_valid/in_ready : request handshake
//   out_data/out_sel  : selected value and the index that produced it
//   out_last          : scan-mode output from the last channel
//   out_valid/out_ready : output handshake
module mux_pipe_param #(
   parameter int WIDTH = 4,
   parameter int SEL_W = 6
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [(1<<SEL_W)*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]            sel,
   input  logic                        mode,
   input  logic                        scan_clr,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [SEL_W-1:0]            out_sel,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready
);
   localparam int NUM_IN = 1 << SEL_W;
   logic [WIDTH-1:0] ch [NUM_IN];
   logic s2_load, s1_en, accept;
   logic [SEL_W-1:0] idx;
   logic [SEL_W-2:0] off;
   logic s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d;
   logic [WIDTH-1:0] s1_lo_q, s1_lo_d, s1_hi_q, s1_hi_d;
   logic [SEL_W-1:0] s1_idx_q, s1_idx_d, cnt_q, cnt_d;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   genvar g;
   for (g = 0; g < NUM_IN; g++) begin : g_ch
      assign ch[g] = in_bus[g*WIDTH +: WIDTH];
   end
   always_comb begin
      s2_load     = s1_valid_q && (!out_valid_q || out_ready);
      s1_en       = !s1_valid_q || s2_load;
      accept      = in_valid && s1_en;
      idx         = mode ? (scan_clr ? '0 : cnt_q) : sel;
      off         = idx[SEL_W-2:0];
      // clear takes priority but a same-cycle scan accept consumes index 0, leaving 1
      cnt_d       = (scan_clr ? '0 : cnt_q) + SEL_W'(accept && mode);
      s1_valid_d  = s1_en ? accept : s1_valid_q;
      // first level of the mux: pick the same offset from both halves
      s1_lo_d     = accept ? ch[{1'b0, off}] : s1_lo_q;
      s1_hi_d     = accept ? ch[{1'b1, off}] : s1_hi_q;
      s1_idx_d    = accept ? idx : s1_idx_q;
      s1_mode_d   = accept ? mode : s1_mode_q;
      out_valid_d = s2_load || (out_valid_q && !out_ready);
      out_data_d  = s2_load ? (s1_idx_q[SEL_W-1] ? s1_hi_q : s1_lo_q) : out_data_q;
      out_sel_d   = s2_load ? s1_idx_q : out_sel_q;
      out_last_d  = s2_load ? (s1_mode_q && &s1_idx_q) : out_last_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= 1'b0;
         s1_lo_q     <= '0;
         s1_hi_q     <= '0;
         s1_idx_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_mode_q   <= s1_mode_d;
         s1_lo_q     <= s1_lo_d;
         s1_hi_q     <= s1_hi_d;
         s1_idx_q    <= s1_idx_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end
   assign in_ready  = s1_en;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_last  = out_last_q;
endmodule

// File: tb/tb_mux_pipe_param.sv
// tb_mux_pipe_param: scoreboard bench for mux_pipe_param (4x64 directed/random, 8x4 random)
module tb_mux_pipe_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b1;
   logic [255:0] a_bus;
   logic [5:0] a_sel, a_os;
   logic [3:0] a_od;
   logic a_mode, a_clr, a_iv, a_ir, a_ol, a_ov, a_or;
   logic [31:0] b_bus;
   logic [1:0] b_sel, b_os;
   logic [7:0] b_od;
   logic b_mode, b_clr, b_iv, b_ir, b_ol, b_ov, b_or;
   mux_pipe_param #(.WIDTH(4), .SEL_W(6)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_bus(a_bus), .sel(a_sel), .mode(a_mode), .scan_clr(a_clr),
      .in_valid(a_iv), .in_ready(a_ir), .out_data(a_od), .out_sel(a_os), .out_last(a_ol),
      .out_valid(a_ov), .out_ready(a_or));
   mux_pipe_param #(.WIDTH(8), .SEL_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_bus(b_bus), .sel(b_sel), .mode(b_mode), .scan_clr(b_clr),
      .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od), .out_sel(b_os), .out_last(b_ol),
      .out_valid(b_ov), .out_ready(b_or));
   typedef struct {int d; int s; bit l; int t; bit st;} exp_t;
   exp_t qa[$], qb[$];
   int cnt[2];
   bit strict[2];
   int cyc = 0;
   int n_vec = 0, n_err = 0;
   logic [255:0] pat;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic void chk(string nm, longint act, longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction
   task automatic mon(input int d, input bit ov, input bit ordy, input int od, input int os, input bit ol);
      exp_t e;
      if (!(ov && ordy)) return;
      if ((d == 0 ? qa.size() : qb.size()) == 0) begin
         chk(d == 0 ? "a_spurious_out" : "b_spurious_out", 1, 0);
         return;
      end
      if (d == 0) e = qa.pop_front();
      else e = qb.pop_front();
      chk("out_data", od, e.d);
      chk("out_sel", os, e.s);
      chk("out_last", ol, e.l);
      if (e.st) chk("latency", cyc - e.t, 2);
      else chk("latency_min", int'(cyc - e.t >= 2), 1);
   endtask
   always @(negedge clk) mon(0, a_ov, a_or, int'(a_od), int'(a_os), a_ol);
   always @(negedge clk) mon(1, b_ov, b_or, int'(b_od), int'(b_os), b_ol);
   // one request cycle: drive, then predict acceptance from the in-flight count
   task automatic step(input int d, input bit iv, input int sel, input bit mode, input bit clr,
                       input bit ordy, input logic [255:0] bus, output bit acc);
      int n, w, base, idx;
      bit rdy;
      logic [255:0] sh;
      n = d == 0 ? 64 : 4;
      w = d == 0 ? 4 : 8;
      @(posedge clk);
      #1;
      if (d == 0) begin
         a_iv = iv; a_sel = 6'(sel); a_mode = mode; a_clr = clr; a_or = ordy; a_bus = bus;
      end else begin
         b_iv = iv; b_sel = 2'(sel); b_mode = mode; b_clr = clr; b_or = ordy; b_bus = bus[31:0];
      end
      @(negedge clk);
      #1;
      rdy = (d == 0 ? qa.size() : qb.size()) < 2 || ordy;
      chk(d == 0 ? "a_in_ready" : "b_in_ready", d == 0 ? a_ir : b_ir, rdy);
      acc = iv && rdy;
      base = clr ? 0 : cnt[d];
      idx = mode ? base : sel % n;
      if (acc) begin
         exp_t e;
         sh = bus >> (idx * w);
         e.d = int'(sh[7:0]) & ((1 << w) - 1);
         e.s = idx;
         e.l = mode && idx == n - 1;
         e.t = cyc;
         e.st = strict[d];
         if (d == 0) qa.push_back(e);
         else qb.push_back(e);
      end
      cnt[d] = (base + int'(acc && mode)) % n;
   endtask
   task automatic send(input int d, input int sel, input bit mode, input bit clr, input bit ordy,
                       input logic [255:0] bus);
      bit acc;
      int k = 0;
      do begin
         step(d, 1'b1, sel, mode, clr, ordy, bus, acc);
         k++;
      end while (!acc && k < 20);
      if (!acc) chk("send_timeout", 0, 1);
   endtask
   task automatic idle(input int d, input int k);
      bit acc;
      repeat (k) step(d, 1'b0, 0, 1'b0, 1'b0, 1'b1, '0, acc);
   endtask
   task automatic rnd(input int d);
      bit acc;
      logic [255:0] rb;
      for (int i = 0; i < 8; i++) rb[i*32 +: 32] = $urandom;
      step(d, $urandom_range(0, 3) != 0, int'($urandom_range(0, 63)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rb, acc);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
   initial begin
      bit acc;
      for (int k = 0; k < 64; k++) pat[k*4 +: 4] = 4'(k);
      {a_iv, a_sel, a_mode, a_clr, a_bus} = '0;
      {b_iv, b_sel, b_mode, b_clr, b_bus} = '0;
      a_or = 1'b1;
      b_or = 1'b1;
      cnt[0] = 0; cnt[1] = 0;
      strict[0] = 1'b0; strict[1] = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", a_ov, 0);
      chk("rst_out_data", a_od, 0);
      chk("rst_out_sel", a_os, 0);
      chk("rst_out_last", a_ol, 0);
      chk("rst_in_ready", a_ir, 1);
      chk("rst_b_out_valid", b_ov, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // direct selects across both halves, no backpressure
      strict[0] = 1'b1;
      send(0, 0, 0, 0, 1, pat);
      send(0, 31, 0, 0, 1, pat);
      send(0, 32, 0, 0, 1, pat);
      send(0, 63, 0, 0, 1, pat);
      idle(0, 4);
      // full scan with wrap
      repeat (65) send(0, 0, 1, 0, 1, pat);
      idle(0, 4);
      strict[0] = 1'b0;
      // backpressure with both stages full
      send(0, 5, 0, 0, 1, pat);
      send(0, 6, 0, 0, 1, pat);
      send(0, 7, 0, 0, 1, pat);
      repeat (4) step(0, 1'b1, 9, 1'b0, 1'b0, 1'b0, pat, acc);
      idle(0, 6);
      // scan clear coinciding with a scan accept at counter 40
      step(0, 1'b0, 0, 1'b0, 1'b1, 1'b1, pat, acc);
      repeat (40) send(0, 0, 1, 0, 1, pat);
      send(0, 0, 1, 1, 1, pat);
      send(0, 17, 0, 0, 1, pat);
      send(0, 0, 1, 0, 1, pat);
      idle(0, 4);
      // reset with both stages occupied
      send(0, 3, 0, 0, 0, pat);
      send(0, 4, 0, 0, 0, pat);
      step(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, pat, acc);
      chk("full_out_valid", a_ov, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      cnt[0] = 0; cnt[1] = 0;
      #1;
      chk("midrst_out_valid", a_ov, 0);
      chk("midrst_out_sel", a_os, 0);
      chk("midrst_in_ready", a_ir, 1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      idle(0, 4);
      send(0, 0, 1, 0, 1, pat);
      idle(0, 4);
      repeat (300) rnd(0);
      idle(0, 5);
      repeat (10000) rnd(1);
      idle(1, 5);
      chk("a_drained", qa.size(), 0);
      chk("b_drained", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
